rsa_host_sequencer: RTL and testbench
=====================================

// Module: rsa_host_sequencer
// PURPOSE
//  Host-side initiator for rsa_unit. Accepts operands P, E, M, Const as a
//  byte-serial stream over a valid/ready bus and holds them stable on the
//  unit's operand inputs. Runs the unit and waits for end-of-conversion
//  (eoc). Captures result C and returns it over a valid/ready output bus.
//  Sits between the pin-level top wrapper and rsa_unit.
// PARAMETERS
//  WIDTH        8     operand/result width; equals rsa_unit operand width
//  TIMEOUT_CYC  1024  max cycles in WAIT before abort; 0 disables timeout
//  TO_W         11    timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk          in   1      clock; all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  abort        in   1      synchronous abort; return to IDLE next cycle
//  din          in   WIDTH  operand word
//  din_valid    in   1      din is valid
//  din_ready    out  1      sequencer accepts din this cycle
//  op_p         out  WIDTH  operand P to rsa_unit
//  op_e         out  WIDTH  operand E to rsa_unit
//  op_m         out  WIDTH  operand M to rsa_unit
//  op_const     out  WIDTH  operand Const to rsa_unit
//  rsa_en       out  1      run enable to rsa_unit
//  rsa_eoc      in   1      end-of-conversion from rsa_unit (level)
//  rsa_c        in   WIDTH  result C from rsa_unit
//  dout         out  WIDTH  captured result
//  dout_valid   out  1      dout is valid
//  dout_ready   in   1      consumer accepts dout
//  busy         out  1      high in any state other than IDLE
//  timeout_err  out  1      sticky; set on WAIT timeout
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including op_* and dout.
//  Transfers: din transfers when din_valid & din_ready. dout transfers when
//   dout_valid & dout_ready.
//  States: IDLE, LOAD, START, WAIT, OUT.
//  IDLE: din_ready=1.
//   - On a transfer: din -> op_p, idx=1, go to LOAD, clear timeout_err.
//  LOAD: din_ready=1.
//   - Each transfer writes op_e (idx 1), op_m (idx 2), op_const (idx 3).
//   - The transfer at idx 3 goes to START.
//   - No transfer: hold state and idx; no timeout in LOAD.
//  START: exactly 1 cycle.
//   - rsa_en=1, eoc_prev<=rsa_eoc, timeout counter<=0, go to WAIT.
//  WAIT: rsa_en=1; eoc_prev<=rsa_eoc each cycle.
//   - Done: rsa_eoc=1 & eoc_prev=0 (rising edge). Then dout<=rsa_c,
//     rsa_en<=0, go to OUT.
//   - A stale eoc held high from a previous run does not count as done.
//   - Timeout: counter reaches TIMEOUT_CYC-1 without done. Then set
//     timeout_err, rsa_en<=0, go to IDLE. dout is unchanged.
//   - Done and timeout in the same cycle: done wins.
//  OUT: dout_valid=1; dout held stable until transfer.
//   - On transfer: dout_valid<=0, go to IDLE.
//  din_ready=0 in START, WAIT and OUT.
//  Operand stability: op_* change only on din transfers.
//  Latency:
//   - last operand transfer -> rsa_en high: 1 cycle.
//   - eoc rising edge -> dout_valid high: 1 cycle.
//  abort (any state): next cycle state=IDLE, rsa_en=0, dout_valid=0, idx=0.
//   - op_*, dout and timeout_err are retained.
//   - abort wins over all same-cycle events, including a din transfer.
//  rst wins over abort.
// STRUCTURE
//  rsa_pkg (shared):
//   - state encoding constants: IDLE=0, LOAD=1, START=2, WAIT=3, OUT=4
//   - operand index constants: IDX_P..IDX_CONST = 0..3
//  Sub-module rsa_wdog_counter:
//   - TO_W-bit counter with clear/enable; flags expiry at TIMEOUT_CYC-1.
//   - Tied off to never expire when TIMEOUT_CYC=0.
//  FSM, operand registers and eoc edge detect live in this module.
// TESTING
//  1 Normal run:
//    - stream 8'h0D,8'h05,8'h07,8'h03 with valid held high
//    - check op_p=0D, op_e=05, op_m=07, op_const=03
//    - check rsa_en high the cycle after the 4th transfer
//    - model pulses eoc with C=8'h2A: dout=2A, dout_valid=1 one cycle later
//  2 Backpressure:
//    - dout_ready=0 for 5 cycles: dout_valid and dout stay stable
//    - ready=1: IDLE next cycle
//  3 Stale eoc:
//    - rsa_eoc held 1 through START
//    - no capture until eoc goes 0 then 1
//  4 Timeout:
//    - TIMEOUT_CYC=16, eoc never rises
//    - timeout_err=1 and state IDLE 16 cycles after entering WAIT
//    - timeout_err clears on the next first-word transfer
//  5 Abort:
//    - assert abort in LOAD at idx 2 together with a din transfer
//    - next cycle IDLE, busy=0, op_m unchanged
//  6 Reset mid-WAIT:
//    - rst=1 for 1 cycle
//    - all outputs 0 and IDLE on the following cycle

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA host sequencer: FSM state encoding and operand slot indices.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam logic [1:0] IDX_P     = 2'd0;
    localparam logic [1:0] IDX_E     = 2'd1;
    localparam logic [1:0] IDX_M     = 2'd2;
    localparam logic [1:0] IDX_CONST = 2'd3;

endpackage

// File: rtl/rsa_wdog_counter.sv
// Watchdog counter for the WAIT state. It has a clear and an enable input.
// It flags expiry when the count reaches TIMEOUT_CYC-1 and never expires when TIMEOUT_CYC is 0.
module rsa_wdog_counter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic clk,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT_CYC == 0) begin : g_never
            assign expired_o = 1'b0;
        end else begin : g_cmp
            assign expired_o = (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host-side initiator for rsa_unit. It loads four operands byte-serially, runs the unit until the eoc rising edge,
// and returns result C over a valid/ready bus.
module rsa_host_sequencer
    import rsa_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] op_p,
    output logic [WIDTH-1:0] op_e,
    output logic [WIDTH-1:0] op_m,
    output logic [WIDTH-1:0] op_const,
    output logic             rsa_en,
    input  logic             rsa_eoc,
    input  logic [WIDTH-1:0] rsa_c,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             timeout_err
);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] op_p_q, op_p_d, op_e_q, op_e_d;
    logic [WIDTH-1:0] op_m_q, op_m_d, op_const_q, op_const_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             terr_q, terr_d;
    logic             eoc_prev_q, eoc_prev_d;
    logic             wd_clr, wd_en, wd_expired;
    logic             din_xfer, done;

    rsa_wdog_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wdog (
        .clk       (clk),
        .rst_i     (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    assign din_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign din_xfer   = din_valid && din_ready;
    assign done       = (state_q == ST_WAIT) && rsa_eoc && !eoc_prev_q;
    assign rsa_en     = (state_q == ST_START) || (state_q == ST_WAIT);
    assign dout_valid = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_p_d     = op_p_q;
        op_e_d     = op_e_q;
        op_m_d     = op_m_q;
        op_const_d = op_const_q;
        dout_d     = dout_q;
        terr_d     = terr_q;
        eoc_prev_d = eoc_prev_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (din_xfer) begin
                op_p_d  = din;
                idx_d   = IDX_E;
                terr_d  = 1'b0;
                state_d = ST_LOAD;
            end
            ST_LOAD: if (din_xfer) begin
                idx_d = idx_q + 2'd1;
                unique case (idx_q)
                    IDX_E:   op_e_d = din;
                    IDX_M:   op_m_d = din;
                    default: begin
                        op_const_d = din;
                        state_d    = ST_START;
                    end
                endcase
            end
            ST_START: begin
                eoc_prev_d = rsa_eoc;
                wd_clr     = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                eoc_prev_d = rsa_eoc;
                wd_en      = 1'b1;
                // A completion edge beats a timeout that expires in the same cycle.
                if (done) begin
                    dout_d  = rsa_c;
                    state_d = ST_OUT;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: if (dout_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort discards any same-cycle update but keeps operands, result and error flag.
        if (abort) begin
            state_d    = ST_IDLE;
            idx_d      = IDX_P;
            op_p_d     = op_p_q;
            op_e_d     = op_e_q;
            op_m_d     = op_m_q;
            op_const_d = op_const_q;
            dout_d     = dout_q;
            terr_d     = terr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_P;
            op_p_q     <= '0;
            op_e_q     <= '0;
            op_m_q     <= '0;
            op_const_q <= '0;
            dout_q     <= '0;
            terr_q     <= 1'b0;
            eoc_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_p_q     <= op_p_d;
            op_e_q     <= op_e_d;
            op_m_q     <= op_m_d;
            op_const_q <= op_const_d;
            dout_q     <= dout_d;
            terr_q     <= terr_d;
            eoc_prev_q <= eoc_prev_d;
        end
    end

    assign op_p        = op_p_q;
    assign op_e        = op_e_q;
    assign op_m        = op_m_q;
    assign op_const    = op_const_q;
    assign dout        = dout_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Directed bench for rsa_host_sequencer.
// Expected results are queued by the stimulus process and checked by a monitor on each dout transfer.
module tb_rsa_host_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [7:0] op_p, op_e, op_m, op_const;
    logic       rsa_en;
    logic       rsa_eoc = 1'b0;
    logic [7:0] rsa_c = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rsa_host_sequencer #(
        .WIDTH       (8),
        .TIMEOUT_CYC (16),
        .TO_W        (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .op_p        (op_p),
        .op_e        (op_e),
        .op_m        (op_m),
        .op_const    (op_const),
        .rsa_en      (rsa_en),
        .rsa_eoc     (rsa_eoc),
        .rsa_c       (rsa_c),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams four words with din_valid held high; returns just after the 4th transfer edge.
    task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        logic [7:0] w[4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = w[i];
            step();
        end
        din_valid = 1'b0;
    endtask

    // Scoreboard monitor: a dout transfer must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL dout_unexpected: got %0h required none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("dout transfer: got %0h required %0h", dout, e);
                if (dout !== e) begin
                    n_bad++;
                    $display("FAIL dout_scoreboard: got %0h required %0h", dout, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout: got hang required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        step(); step();
        rst = 1'b0;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_rsa_en", {7'd0, rsa_en}, 8'd0);
        check("rst_dout_valid", {7'd0, dout_valid}, 8'd0);
        check("rst_dout", dout, 8'h00);
        check("rst_op_p", op_p, 8'h00);
        check("rst_op_const", op_const, 8'h00);
        check("rst_terr", {7'd0, timeout_err}, 8'd0);
        check("idle_din_ready", {7'd0, din_ready}, 8'd1);

        // 1: normal run
        load4(8'h0D, 8'h05, 8'h07, 8'h03);
        check("t1_rsa_en_start", {7'd0, rsa_en}, 8'd1);
        check("t1_din_ready_start", {7'd0, din_ready}, 8'd0);
        check("t1_op_p", op_p, 8'h0D);
        check("t1_op_e", op_e, 8'h05);
        check("t1_op_m", op_m, 8'h07);
        check("t1_op_const", op_const, 8'h03);
        step();
        check("t1_rsa_en_wait", {7'd0, rsa_en}, 8'd1);
        rsa_c = 8'h2A; rsa_eoc = 1'b1;
        exp_q.push_back(8'h2A);
        step();
        rsa_eoc = 1'b0;
        check("t1_dout_valid", {7'd0, dout_valid}, 8'd1);
        check("t1_dout", dout, 8'h2A);
        check("t1_rsa_en_out", {7'd0, rsa_en}, 8'd0);
        step();
        check("t1_idle", {7'd0, busy}, 8'd0);

        // 2: backpressure
        dout_ready = 1'b0;
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        step();
        rsa_c = 8'h5A; rsa_eoc = 1'b1;
        step();
        rsa_eoc = 1'b0; rsa_c = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", {7'd0, dout_valid}, 8'd1);
            check("t2_hold_dout", dout, 8'h5A);
            step();
        end
        exp_q.push_back(8'h5A);
        dout_ready = 1'b1;
        step();
        check("t2_idle", {7'd0, busy}, 8'd0);
        check("t2_valid_drop", {7'd0, dout_valid}, 8'd0);

        // 3: stale eoc held through START
        din_valid = 1'b1;
        din = 8'h01; step();
        din = 8'h02; step();
        din = 8'h03; step();
        rsa_eoc = 1'b1; rsa_c = 8'h99;
        din = 8'h04; step();
        din_valid = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_no_capture", {7'd0, dout_valid}, 8'd0);
        end
        rsa_eoc = 1'b0;
        step();
        check("t3_still_wait", {7'd0, busy}, 8'd1);
        rsa_eoc = 1'b1; rsa_c = 8'h77;
        exp_q.push_back(8'h77);
        step();
        rsa_eoc = 1'b0;
        check("t3_dout_valid", {7'd0, dout_valid}, 8'd1);
        check("t3_dout", dout, 8'h77);
        step();

        // 4: timeout with eoc never rising
        load4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        step();
        for (int k = 1; k < 16; k++) begin
            step();
            check("t4_in_wait", {7'd0, busy}, 8'd1);
        end
        step();
        check("t4_idle", {7'd0, busy}, 8'd0);
        check("t4_terr", {7'd0, timeout_err}, 8'd1);
        check("t4_rsa_en", {7'd0, rsa_en}, 8'd0);
        check("t4_dout_kept", dout, 8'h77);
        step();
        check("t4_terr_sticky", {7'd0, timeout_err}, 8'd1);
        din_valid = 1'b1; din = 8'hB1;
        step();
        check("t4_terr_clear", {7'd0, timeout_err}, 8'd0);

        // 5: abort in LOAD at idx 2 together with a transfer
        din = 8'hB2; step();
        din = 8'hEE; abort = 1'b1;
        step();
        abort = 1'b0; din_valid = 1'b0;
        check("t5_idle", {7'd0, busy}, 8'd0);
        check("t5_op_m_kept", op_m, 8'hA3);
        check("t5_op_e_new", op_e, 8'hB2);
        check("t5_rsa_en", {7'd0, rsa_en}, 8'd0);
        step();
        check("t5_stay_idle", {7'd0, busy}, 8'd0);

        // 6: reset in WAIT
        load4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        step(); step();
        check("t6_pre_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy", {7'd0, busy}, 8'd0);
        check("t6_rsa_en", {7'd0, rsa_en}, 8'd0);
        check("t6_dout", dout, 8'h00);
        check("t6_dout_valid", {7'd0, dout_valid}, 8'd0);
        check("t6_op_p", op_p, 8'h00);
        check("t6_op_e", op_e, 8'h00);
        check("t6_op_m", op_m, 8'h00);
        check("t6_op_const", op_const, 8'h00);
        check("t6_terr", {7'd0, timeout_err}, 8'd0);

        step(); step();
        check("end_queue_empty", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
